iter_div_axis: RTL and testbench
================================

// Module: iter_div_axis
// PURPOSE
//  Multi-cycle 32/32 radix-2 restoring divider. It is the responder side of the ALU's divider
//  handshake: AXI-stream-style divisor/dividend slave channels in, one result pulse out.
//  One instance per signedness (SIGNED=1 for DIV, SIGNED=0 for DIVU). The ALU routes
//  dout_tdata[31:0] to HI and dout_tdata[63:32] to LO.
// PARAMETERS
//  SIGNED  1  1: two's-complement operands and results; 0: unsigned
// PORTS
//  clk                     in   1   clock; all state updates on the rising edge
//  reset                   in   1   synchronous, active-high
//  s_axis_divisor_tvalid   in   1   divisor valid
//  s_axis_divisor_tready   out  1   divisor ready
//  s_axis_divisor_tdata    in   32  divisor
//  s_axis_dividend_tvalid  in   1   dividend valid
//  s_axis_dividend_tready  out  1   dividend ready
//  s_axis_dividend_tdata   in   32  dividend
//  m_axis_dout_tvalid      out  1   result valid, one-cycle pulse; no back-pressure
//  m_axis_dout_tdata       out  64  {quotient[31:0], remainder[31:0]}
// BEHAVIOUR
//  - Clock and reset: one clock (clk). reset is synchronous, active-high.
//  - Reset: state=IDLE, capture flags=0, iteration counter=0, m_axis_dout_tvalid=0,
//    m_axis_dout_tdata=0. Both treadys are forced 0 while reset=1.
//    Reset mid-operation aborts the operation with no result pulse.
//  - FSM states: IDLE -> PREP -> ITER -> DONE -> IDLE.
//  - IDLE:
//    - Each channel's tready = 1 while that channel is not yet captured.
//    - A beat (tvalid & tready) latches tdata and sets that channel's flag.
//    - The channels are independent; both may complete on the same edge.
//    - When both operands are held (from flags or from beats on this edge) -> PREP.
//      Call this edge the acceptance edge E0.
//  - PREP: form magnitudes (SIGNED: abs of each operand; record sign_q = sign(dend)^sign(dsor)
//    and sign_r = sign(dend)). Clear partial remainder; counter=0. -> ITER. Treadys = 0.
//  - ITER, one step per edge:
//    - Shift {rem,quo} left by 1 and trial-subtract the magnitude divisor (33-bit compare).
//    - Set the quotient bit if rem >= divisor.
//    - Counter increments; after the 32nd step (counter==31) -> DONE. Treadys = 0.
//  - DONE:
//    - m_axis_dout_tvalid = 1 for exactly one cycle.
//    - tdata = sign-fixed {q,r}: negate q if sign_q, negate r if sign_r.
//    - Clear flags -> IDLE.
//    - tdata holds its value until the next DONE. Treadys = 0.
//  - Latency: tvalid is high in the cycle starting 33 edges after E0.
//    Minimum issue interval is 35 cycles.
//  - Divide by zero (no trap, deterministic):
//    - Magnitude q = 0xFFFFFFFF, r = |dividend|, then the normal sign fix is applied.
//    - SIGNED: q = 0xFFFFFFFF if dividend>=0, else 0x00000001; r = dividend.
//  - Overflow (SIGNED, 0x80000000 / 0xFFFFFFFF): q = 0x80000000, r = 0, no flag.
//  - Beats offered outside IDLE are not accepted (tready=0); the master must hold tvalid.
//  - An input tvalid dropping after capture has no effect: the captured value stands.
// TESTING
//  1. SIGNED=0: divisor 7, dividend 100 on the same edge -> tvalid pulse 33 cycles later;
//     tdata = {32'd14, 32'd2}; tvalid high for exactly 1 cycle.
//  2. SIGNED=1: dividend -7 (0xFFFFFFF9), divisor 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1);
//     also 7/-2 -> q=-3, r=1.
//  3. Staggered channels: dividend beat at cycle 0, divisor at cycle 5 ->
//     dividend_tready drops after cycle 0; E0 = cycle 5; result 33 cycles after cycle 5.
//  4. Divide by zero: SIGNED=0, 0x12345678/0 -> {0xFFFFFFFF, 0x12345678};
//     SIGNED=1, -5/0 -> {0x00000001, 0xFFFFFFFB}.
//  5. SIGNED=1 overflow 0x80000000/0xFFFFFFFF -> {0x80000000, 0}.
//     Unsigned 0xFFFFFFFF/1 -> {0xFFFFFFFF, 0}.
//  6. Reset asserted at ITER step 10 -> no tvalid pulse; tdata=0; treadys=1 the cycle after
//     reset deasserts; the next op (9/3) returns {3,0} with full latency.

Source files
------------

// File: rtl/iter_div_axis_if.sv
// Handshake bundle between the ALU and the iterative divider:
// divisor and dividend stream channels in, one result pulse out.
interface iter_div_axis_if;
  logic        s_axis_divisor_tvalid;
  logic        s_axis_divisor_tready;
  logic [31:0] s_axis_divisor_tdata;
  logic        s_axis_dividend_tvalid;
  logic        s_axis_dividend_tready;
  logic [31:0] s_axis_dividend_tdata;
  logic        m_axis_dout_tvalid;
  logic [63:0] m_axis_dout_tdata;

  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tready, s_axis_dividend_tready,
    output m_axis_dout_tvalid, m_axis_dout_tdata
  );

  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tready, s_axis_dividend_tready,
    input  m_axis_dout_tvalid, m_axis_dout_tdata
  );
endinterface

// File: rtl/iter_div_axis.sv
// 32/32 radix-2 restoring divider, 32 iterations per operation.
// Result is {quotient, remainder}, sign-fixed when SIGNED=1.
module iter_div_axis #(
  parameter bit SIGNED = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  iter_div_axis_if.slave axis
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] dsor_r;
  logic [31:0] dend_r;
  logic        dsor_flag_r;
  logic        dend_flag_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [4:0]  cnt_r;
  logic        sign_q_r;
  logic        sign_r_r;
  logic        dout_tvalid_r;
  logic [63:0] dout_tdata_r;

  logic        dsor_rdy_s;
  logic        dend_rdy_s;
  logic        dsor_beat_s;
  logic        dend_beat_s;
  logic [32:0] shift_s;
  logic        ge_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;

  function automatic logic [31:0] magnitude(input logic [31:0] v);
    if (SIGNED && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

  // Handshake readiness and one restoring step on the current partial remainder
  always_comb begin
    dsor_rdy_s  = 1'b0;
    dend_rdy_s  = 1'b0;
    if (!reset && (state_r == IDLE)) begin
      dsor_rdy_s = !dsor_flag_r;
      dend_rdy_s = !dend_flag_r;
    end else begin
      dsor_rdy_s = 1'b0;
      dend_rdy_s = 1'b0;
    end
    dsor_beat_s = dsor_rdy_s && axis.s_axis_divisor_tvalid;
    dend_beat_s = dend_rdy_s && axis.s_axis_dividend_tvalid;

    // rem < divisor holds between steps, so the difference always fits in 32 bits
    shift_s    = {rem_r, quo_r[31]};
    ge_s       = (shift_s >= {1'b0, dsor_r});
    rem_next_s = shift_s[31:0];
    if (ge_s) begin
      rem_next_s = shift_s[31:0] - dsor_r;
    end else begin
      rem_next_s = shift_s[31:0];
    end
    quo_next_s = {quo_r[30:0], ge_s};

    if (sign_q_r) begin
      q_fix_s = 32'd0 - quo_next_s;
    end else begin
      q_fix_s = quo_next_s;
    end
    if (sign_r_r) begin
      r_fix_s = 32'd0 - rem_next_s;
    end else begin
      r_fix_s = rem_next_s;
    end
  end

  assign axis.s_axis_divisor_tready  = dsor_rdy_s;
  assign axis.s_axis_dividend_tready = dend_rdy_s;
  assign axis.m_axis_dout_tvalid     = dout_tvalid_r;
  assign axis.m_axis_dout_tdata      = dout_tdata_r;

  // Operand capture, iteration sequencing and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      dsor_r        <= 32'd0;
      dend_r        <= 32'd0;
      dsor_flag_r   <= 1'b0;
      dend_flag_r   <= 1'b0;
      rem_r         <= 32'd0;
      quo_r         <= 32'd0;
      cnt_r         <= 5'd0;
      sign_q_r      <= 1'b0;
      sign_r_r      <= 1'b0;
      dout_tvalid_r <= 1'b0;
      dout_tdata_r  <= 64'd0;
    end else begin
      dout_tvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (dsor_beat_s) begin
            dsor_r      <= axis.s_axis_divisor_tdata;
            dsor_flag_r <= 1'b1;
          end
          if (dend_beat_s) begin
            dend_r      <= axis.s_axis_dividend_tdata;
            dend_flag_r <= 1'b1;
          end
          if ((dsor_flag_r || dsor_beat_s) && (dend_flag_r || dend_beat_s)) begin
            state_r <= PREP;
          end
        end
        PREP: begin
          sign_q_r <= SIGNED && (dend_r[31] ^ dsor_r[31]);
          sign_r_r <= SIGNED && dend_r[31];
          dsor_r   <= magnitude(dsor_r);
          quo_r    <= magnitude(dend_r);
          rem_r    <= 32'd0;
          cnt_r    <= 5'd0;
          state_r  <= ITER;
        end
        ITER: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 5'd1;
          // The last step's result goes straight to the output register
          if (cnt_r == 5'd31) begin
            state_r       <= DONE;
            dout_tvalid_r <= 1'b1;
            dout_tdata_r  <= {q_fix_s, r_fix_s};
          end
        end
        DONE: begin
          dsor_flag_r <= 1'b0;
          dend_flag_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_axis.sv
// Directed bench for iter_div_axis: one unsigned and one signed instance,
// expected results queued at issue and compared when the result pulse appears.
module tb_iter_div_axis;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iter_div_axis_if du_if ();
  iter_div_axis_if ds_if ();

  iter_div_axis #(.SIGNED(1'b0)) u_divu (.clk(clk), .reset(reset), .axis(du_if));
  iter_div_axis #(.SIGNED(1'b1)) u_div  (.clk(clk), .reset(reset), .axis(ds_if));

  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) begin
      if (sgn && a[31]) return {32'd1, a};
      return {32'hFFFFFFFF, a};
    end
    if (sgn && (a == 32'h80000000) && (b == 32'hFFFFFFFF)) return {32'h80000000, 32'd0};
    if (sgn) begin
      sa = a;
      sb = b;
      return {32'(sa / sb), 32'(sa % sb)};
    end
    return {a / b, a % b};
  endfunction

  function automatic logic tvalid_of(input bit sgn);
    return sgn ? ds_if.m_axis_dout_tvalid : du_if.m_axis_dout_tvalid;
  endfunction

  function automatic logic [63:0] tdata_of(input bit sgn);
    return sgn ? ds_if.m_axis_dout_tdata : du_if.m_axis_dout_tdata;
  endfunction

  function automatic logic [1:0] rdy_of(input bit sgn);
    return sgn ? {ds_if.s_axis_dividend_tready, ds_if.s_axis_divisor_tready}
               : {du_if.s_axis_dividend_tready, du_if.s_axis_divisor_tready};
  endfunction

  task automatic drive(input bit sgn, input bit nv, input logic [31:0] dend,
                       input bit dv, input logic [31:0] dsor);
    if (sgn) begin
      ds_if.s_axis_dividend_tvalid = nv;
      ds_if.s_axis_dividend_tdata  = dend;
      ds_if.s_axis_divisor_tvalid  = dv;
      ds_if.s_axis_divisor_tdata   = dsor;
    end else begin
      du_if.s_axis_dividend_tvalid = nv;
      du_if.s_axis_dividend_tdata  = dend;
      du_if.s_axis_divisor_tvalid  = dv;
      du_if.s_axis_divisor_tdata   = dsor;
    end
  endtask

  // Called #1 after the acceptance edge; expects the pulse 33 edges later
  task automatic wait_result(input bit sgn, input string tag);
    int lat;
    logic [63:0] e;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (tvalid_of(sgn)) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    if (lat != 0) begin
      check({tag, " data"}, tdata_of(sgn), e);
      @(posedge clk);
      #1;
      check({tag, " pulse"}, {63'd0, tvalid_of(sgn)}, 64'd0);
    end
  endtask

  task automatic op(input bit sgn, input logic [31:0] dend, input logic [31:0] dsor,
                    input string tag);
    check({tag, " ready"}, {62'd0, rdy_of(sgn)}, 64'd3);
    exp_q.push_back(model(sgn, dend, dsor));
    drive(sgn, 1'b1, dend, 1'b1, dsor);
    @(posedge clk);
    #1;
    drive(sgn, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_result(sgn, tag);
  endtask

  initial begin
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset tvalid", {63'd0, du_if.m_axis_dout_tvalid}, 64'd0);
    check("reset tdata", du_if.m_axis_dout_tdata, 64'd0);
    check("reset tready", {62'd0, rdy_of(1'b0)}, 64'd0);
    check("reset tready s", {62'd0, rdy_of(1'b1)}, 64'd0);
    reset = 1'b0;
    #1;

    op(1'b0, 32'd100, 32'd7, "divu 100/7");
    op(1'b1, 32'hFFFFFFF9, 32'd2, "div -7/2");
    op(1'b1, 32'd7, 32'hFFFFFFFE, "div 7/-2");

    // Staggered: dividend first, divisor five cycles later
    exp_q.push_back(model(1'b0, 32'd1000, 32'd10));
    drive(1'b0, 1'b1, 32'd1000, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("stagger ready", {62'd0, rdy_of(1'b0)}, 64'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("stagger hold", {63'd0, du_if.m_axis_dout_tvalid}, 64'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd10);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_result(1'b0, "stagger 1000/10");

    op(1'b0, 32'h12345678, 32'd0, "divu by zero");
    op(1'b1, 32'hFFFFFFFB, 32'd0, "div -5/0");
    op(1'b1, 32'h00000009, 32'd0, "div 9/0");
    op(1'b1, 32'h80000000, 32'hFFFFFFFF, "div overflow");
    op(1'b0, 32'hFFFFFFFF, 32'd1, "divu max/1");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd3;
      op(i[0], ra, rb, "random");
    end

    // Reset during ITER step 10 aborts with no pulse
    drive(1'b0, 1'b1, 32'd12345, 1'b1, 32'd7);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid reset tready", {62'd0, rdy_of(1'b0)}, 64'd0);
    @(posedge clk);
    #1;
    check("mid reset tdata", du_if.m_axis_dout_tdata, 64'd0);
    reset = 1'b0;
    #1;
    check("post reset tready", {62'd0, rdy_of(1'b0)}, 64'd3);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (du_if.m_axis_dout_tvalid) pulses++;
    end
    check("aborted pulse", 64'(pulses), 64'd0);
    op(1'b0, 32'd9, 32'd3, "after reset 9/3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
